// File: rtl/core_fetch_unit.sv
// core_fetch_unit: sequential-PC instruction fetch with credit-limited L1I requests and a fetch queue.
// Optional macro CORE_IF_MISALIGN_CHK_EN aligns misaligned redirect targets and flags them on if_misalign.
module core_fetch_unit #(
  parameter logic [31:0] PC_START  = 32'h0000_0200,
  parameter int unsigned FQ_DEPTH  = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        if_stop,
  input  logic        redir_val,
  input  logic [31:0] redir_pc,
  output logic        l1i_req_val,
  input  logic        l1i_req_rdy,
  output logic [31:0] l1i_req_addr,
  input  logic        l1i_resp_val,
  input  logic [31:0] l1i_resp_data,
  output logic        dec_val,
  input  logic        dec_rdy,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_4,
  output logic [31:0] dec_instr,
  output logic        if_misalign
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

  localparam logic [OW-1:0] OUT_ZERO = OW'(1'b0);
  localparam logic [OW-1:0] OUT_ONE  = OW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  logic [31:0]   pc_r;
  logic [31:0]   resp_pc_r;
  logic [31:0]   redir_tgt_s;
  logic [OW-1:0] outst_r;
  logic [OW-1:0] drop_r;
  logic [OW-1:0] outst_nxt_s;
  logic [OW-1:0] resp_dec_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [31:0]   fq_pc_r    [FQ_DEPTH];
  logic [31:0]   fq_instr_r [FQ_DEPTH];
  logic [31:0]   credit_s;
  logic          req_ok_s;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;

`ifdef CORE_IF_MISALIGN_CHK_EN
  logic misalign_r;

  assign redir_tgt_s = {redir_pc[31:2], 2'b00};

  // One-cycle flag for a redirect whose target had to be aligned
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= redir_val & (redir_pc[1:0] != 2'b00);
    end
  end

  assign if_misalign = misalign_r;
`else
  assign redir_tgt_s = redir_pc;
  assign if_misalign = 1'b0;
`endif

  // Issue credit: in-flight live requests plus queued entries must leave a free queue slot
  always_comb begin
    credit_s    = 32'(outst_r) - 32'(drop_r) + 32'(count_r);
    req_ok_s    = (32'(outst_r) < MAX_OUTST) && (credit_s < FQ_DEPTH);
    l1i_req_val = n_rst & ~if_stop & ~redir_val & req_ok_s;
    issue_s     = l1i_req_val & l1i_req_rdy;
    push_s      = n_rst & l1i_resp_val & (drop_r == OUT_ZERO) & ~redir_val;
    dec_val     = n_rst & (count_r != CNT_ZERO) & ~redir_val;
    pop_s       = dec_val & dec_rdy;
    resp_dec_s  = l1i_resp_val ? OUT_ONE : OUT_ZERO;
    outst_nxt_s = outst_r + (issue_s ? OUT_ONE : OUT_ZERO) - resp_dec_s;
    count_nxt_s = count_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
  end

  // Fetch control state; a redirect squashes everything still in flight
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pc_r      <= PC_START;
      resp_pc_r <= PC_START;
      outst_r   <= OUT_ZERO;
      drop_r    <= OUT_ZERO;
      count_r   <= CNT_ZERO;
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
    end else if (redir_val) begin
      pc_r      <= redir_tgt_s;
      resp_pc_r <= redir_tgt_s;
      outst_r   <= outst_r - resp_dec_s;
      drop_r    <= outst_r - resp_dec_s;
      count_r   <= CNT_ZERO;
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
    end else begin
      if (issue_s) begin
        pc_r <= pc_r + 32'd4;
      end
      if (l1i_resp_val && (drop_r != OUT_ZERO)) begin
        drop_r <= drop_r - OUT_ONE;
      end
      if (push_s) begin
        resp_pc_r <= resp_pc_r + 32'd4;
        wr_ptr_r  <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      outst_r <= outst_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Fetch queue storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fq_pc_r[wr_ptr_r]    <= resp_pc_r;
      fq_instr_r[wr_ptr_r] <= l1i_resp_data;
    end
  end

  assign l1i_req_addr = pc_r;
  assign dec_pc       = fq_pc_r[rd_ptr_r];
  assign dec_instr    = fq_instr_r[rd_ptr_r];
  assign dec_pc_4     = dec_pc + 32'd4;

endmodule
